// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: FSM encoding,
// address-slice constants and the access-fault classifier.
package dmem_pkg;

  localparam int BOFS_W  = 2;          // byte offset inside a 32-bit word
  localparam int DMEM_AW = 6;          // default word-address width
  localparam int WIDX_LO = BOFS_W;     // low bit of the word index in a byte address

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_RD      = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_RESP    = 3'd4;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  // Misalignment takes priority; anything above the memory's byte range is RANGE.
  function automatic logic [1:0] fault_cause(input logic [31:0] addr, input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + BOFS_W);
    if (addr[BOFS_W-1:0] != 2'd0) begin
      fault_cause = FAULT_MISALIGN;
    end else if (hi != 32'd0) begin
      fault_cause = FAULT_RANGE;
    end else begin
      fault_cause = FAULT_NONE;
    end
  endfunction

endpackage

// File: rtl/dmem_access_unit.sv
// MEM-stage initiator: accepts one load/store per handshake, drives the data
// memory strobes and returns load data; bad addresses raise a fault pulse.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int AW     = DMEM_AW,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic          memwr,
  output logic          memrd,
  output logic [DW-1:0] data,
  output logic [AW-1:0] address,
  input  logic [DW-1:0] datao,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          fault,
  output logic [31:0]   fault_addr,
  output logic          busy
);

  // RD_WAIT lasts RD_LAT cycles: the counter runs RD_LAT-1 down to 0 inclusive.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t     state_r, state_n;
  logic [1:0] cnt_r, cnt_n;
  logic [4:0] rd_r;
  logic [1:0] cause_s;
  logic       accept_s;

  assign cause_s  = fault_cause(req_addr, AW);
  assign accept_s = (state_r == ST_IDLE) && req_valid;

  // Next-state and latency-counter logic.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (cause_s != FAULT_NONE) state_n = ST_IDLE;
          else if (req_we)           state_n = ST_WR;
          else                       state_n = ST_RD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WR:   state_n = ST_IDLE;
      ST_RD: begin
        state_n = ST_RD_WAIT;
        cnt_n   = LAT_INIT;
      end
      ST_RD_WAIT: begin
        if (cnt_r == 2'd0) begin
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt_r - 2'd1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 2'd0;
      rd_r       <= 5'd0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      memwr      <= 1'b0;
      memrd      <= 1'b0;
      data       <= '0;
      address    <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      fault      <= 1'b0;
      fault_addr <= 32'd0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      req_ready <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE);
      memwr     <= (state_n == ST_WR);
      memrd     <= (state_n == ST_RD);
      wb_valid  <= (state_n == ST_RESP);
      fault     <= accept_s && (cause_s != FAULT_NONE);
      if (accept_s && (cause_s != FAULT_NONE)) begin
        fault_addr <= req_addr;
      end
      if (accept_s && (cause_s == FAULT_NONE)) begin
        address <= req_addr[AW+WIDX_LO-1:WIDX_LO];
        if (req_we) begin
          data <= req_wdata;
        end else begin
          rd_r <= req_rd;
        end
      end
      // datao is valid in the last RD_WAIT cycle.
      if ((state_r == ST_RD_WAIT) && (state_n == ST_RESP)) begin
        wb_data <= datao;
        wb_rd   <= rd_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench: one RD_LAT=1 unit and one RD_LAT=3 unit, each with its own
// memory model that returns X outside the valid read-data window.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        v1 = 1'b0;
  logic        v3 = 1'b0;

  logic        a_ready, a_memwr, a_memrd, a_wbv, a_fault, a_busy;
  logic [31:0] a_data, a_wbdata, a_faddr, datao1;
  logic [5:0]  a_address;
  logic [4:0]  a_wbrd;
  logic        b_ready, b_memwr, b_memrd, b_wbv, b_fault, b_busy;
  logic [31:0] b_data, b_wbdata, b_faddr, datao3;
  logic [5:0]  b_address;
  logic [4:0]  b_wbrd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.AW(6), .DW(32), .RD_LAT(1)) u1 (
    .clk(clk), .res(res), .req_valid(v1), .req_ready(a_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .memwr(a_memwr), .memrd(a_memrd), .data(a_data), .address(a_address),
    .datao(datao1), .wb_valid(a_wbv), .wb_rd(a_wbrd), .wb_data(a_wbdata),
    .fault(a_fault), .fault_addr(a_faddr), .busy(a_busy));

  dmem_access_unit #(.AW(6), .DW(32), .RD_LAT(3)) u3 (
    .clk(clk), .res(res), .req_valid(v3), .req_ready(b_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .memwr(b_memwr), .memrd(b_memrd), .data(b_data), .address(b_address),
    .datao(datao3), .wb_valid(b_wbv), .wb_rd(b_wbrd), .wb_data(b_wbdata),
    .fault(b_fault), .fault_addr(b_faddr), .busy(b_busy));

  // Memory models: read data appears RD_LAT cycles after the memrd cycle.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [5:0]  p1 = 6'd0;
  logic        pv1 = 1'b0;
  logic [5:0]  q3 [3];
  logic [2:0]  qv3 = 3'd0;

  always @(posedge clk) begin
    if (a_memwr) mem1[a_address] <= a_data;
    p1  <= a_address;
    pv1 <= a_memrd;
  end
  assign datao1 = pv1 ? mem1[p1] : 32'hxxxx_xxxx;

  always @(posedge clk) begin
    if (b_memwr) mem3[b_address] <= b_data;
    q3[0] <= b_address;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
    qv3   <= {qv3[1:0], b_memrd};
  end
  assign datao3 = qv3[2] ? mem3[q3[2]] : 32'hxxxx_xxxx;

  task automatic test_reset;
    #6;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_ready1 got=%0b exp=1", a_ready); end
    total++; if (a_memwr !== 1'b0 || a_memrd !== 1'b0) begin bad++; $display("FAIL rst_strobes1 got=%0b%0b exp=00", a_memwr, a_memrd); end
    total++; if (a_wbv !== 1'b0 || a_fault !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL rst_pulses1 got=%0b%0b%0b exp=000", a_wbv, a_fault, a_busy); end
    total++; if (b_ready !== 1'b1 || b_memwr !== 1'b0 || b_memrd !== 1'b0) begin bad++; $display("FAIL rst_u3 got=%0b%0b%0b exp=100", b_ready, b_memwr, b_memrd); end
    total++; if (b_wbv !== 1'b0 || b_fault !== 1'b0 || b_faddr !== 32'd0) begin bad++; $display("FAIL rst_u3_out got=%0b%0b%0h exp=0,0,0", b_wbv, b_fault, b_faddr); end
    #1;
    res = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'd9; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    total++; if (a_memwr !== 1'b1 || a_memrd !== 1'b0) begin bad++; $display("FAIL st_strobe got=%0b%0b exp=10", a_memwr, a_memrd); end
    total++; if (a_address !== 6'd5) begin bad++; $display("FAIL st_address got=%0d exp=5", a_address); end
    total++; if (a_data !== 32'd9) begin bad++; $display("FAIL st_data got=%0h exp=9", a_data); end
    total++; if (a_ready !== 1'b0 || a_busy !== 1'b1) begin bad++; $display("FAIL st_busy got=%0b%0b exp=01", a_ready, a_busy); end
    @(posedge clk); #1;
    total++; if (a_memwr !== 1'b0 || a_ready !== 1'b1) begin bad++; $display("FAIL st_done got=%0b%0b exp=01", a_memwr, a_ready); end
    total++; if (a_wbv !== 1'b0) begin bad++; $display("FAIL st_nowb got=%0b exp=0", a_wbv); end
  endtask

  task automatic test_load;
    logic [31:0] la [3];
    logic [4:0]  lr [3];
    logic [31:0] le [3];
    logic [5:0]  lw [3];
    req_we = 1'b1; req_addr = 32'h88; req_wdata = 32'd1; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    total++; if (a_memwr !== 1'b1 || a_address !== 6'd34) begin bad++; $display("FAIL ld_pre_store got=%0b/%0d exp=1/34", a_memwr, a_address); end
    @(posedge clk); #1;
    la[0] = 32'h88; lr[0] = 5'd7;  le[0] = 32'd1; lw[0] = 6'd34;
    la[1] = 32'h14; lr[1] = 5'd31; le[1] = 32'd9; lw[1] = 6'd5;
    la[2] = 32'h88; lr[2] = 5'd0;  le[2] = 32'd1; lw[2] = 6'd34;
    for (int i = 0; i < 3; i++) begin
      req_we = 1'b0; req_addr = la[i]; req_rd = lr[i]; v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
      total++; if (a_memrd !== 1'b1 || a_memwr !== 1'b0 || a_address !== lw[i]) begin bad++; $display("FAIL ld_rd%0d got=%0b%0b/%0d exp=10/%0d", i, a_memrd, a_memwr, a_address, lw[i]); end
      @(posedge clk); #1;
      total++; if (a_memrd !== 1'b0 || a_wbv !== 1'b0) begin bad++; $display("FAIL ld_wait%0d got=%0b%0b exp=00", i, a_memrd, a_wbv); end
      @(posedge clk); #1;
      total++; if (a_wbv !== 1'b1 || a_wbdata !== le[i] || a_wbrd !== lr[i]) begin bad++; $display("FAIL ld_resp%0d got=%0b/%0h/%0d exp=1/%0h/%0d", i, a_wbv, a_wbdata, a_wbrd, le[i], lr[i]); end
      @(posedge clk); #1;
      total++; if (a_wbv !== 1'b0 || a_ready !== 1'b1) begin bad++; $display("FAIL ld_end%0d got=%0b%0b exp=01", i, a_wbv, a_ready); end
    end
  endtask

  task automatic test_fault;
    req_we = 1'b0; req_addr = 32'h06; req_rd = 5'd3; v1 = 1'b1;
    @(posedge clk); #1;
    total++; if (a_fault !== 1'b1 || a_faddr !== 32'h06) begin bad++; $display("FAIL flt_mis got=%0b/%0h exp=1/6", a_fault, a_faddr); end
    total++; if (a_memrd !== 1'b0 || a_memwr !== 1'b0 || a_ready !== 1'b1) begin bad++; $display("FAIL flt_mis_str got=%0b%0b%0b exp=001", a_memrd, a_memwr, a_ready); end
    req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h55;
    @(posedge clk); #1;
    v1 = 1'b0;
    total++; if (a_fault !== 1'b1 || a_faddr !== 32'h100) begin bad++; $display("FAIL flt_rng got=%0b/%0h exp=1/100", a_fault, a_faddr); end
    total++; if (a_memrd !== 1'b0 || a_memwr !== 1'b0 || a_ready !== 1'b1) begin bad++; $display("FAIL flt_rng_str got=%0b%0b%0b exp=001", a_memrd, a_memwr, a_ready); end
    @(posedge clk); #1;
    total++; if (a_fault !== 1'b0 || a_wbv !== 1'b0 || a_memwr !== 1'b0) begin bad++; $display("FAIL flt_end got=%0b%0b%0b exp=000", a_fault, a_wbv, a_memwr); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] sa [2];
    logic [31:0] sd [2];
    logic er, em, ew;
    sa[0] = 32'h14; sd[0] = 32'hA5A5_0001;
    sa[1] = 32'h18; sd[1] = 32'h0000_BEEF;
    for (int i = 0; i < 2; i++) begin
      req_we = 1'b1; req_addr = sa[i]; req_wdata = sd[i]; v3 = 1'b1;
      @(posedge clk); #1;
      v3 = 1'b0;
      total++; if (b_memwr !== 1'b1 || b_data !== sd[i]) begin bad++; $display("FAIL b2b_store%0d got=%0b/%0h exp=1/%0h", i, b_memwr, b_data, sd[i]); end
      @(posedge clk); #1;
    end
    req_we = 1'b0; req_addr = 32'h14; req_rd = 5'd2; v3 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      er = (k == 6);
      em = (k == 1) || (k == 7);
      ew = (k == 5) || (k == 11);
      total++; if (b_ready !== er || b_busy !== ~er) begin bad++; $display("FAIL b2b_ready c%0d got=%0b%0b exp=%0b%0b", k, b_ready, b_busy, er, ~er); end
      total++; if (b_memrd !== em || b_wbv !== ew) begin bad++; $display("FAIL b2b_strobe c%0d got=%0b%0b exp=%0b%0b", k, b_memrd, b_wbv, em, ew); end
      if (k == 1) begin
        req_addr = 32'h18; req_rd = 5'd4;
      end
      if (k == 5) begin
        total++; if (b_wbdata !== 32'hA5A5_0001 || b_wbrd !== 5'd2) begin bad++; $display("FAIL b2b_resp1 got=%0h/%0d exp=a5a50001/2", b_wbdata, b_wbrd); end
      end
      if (k == 7) begin
        v3 = 1'b0;
        total++; if (b_address !== 6'd6) begin bad++; $display("FAIL b2b_addr2 got=%0d exp=6", b_address); end
      end
      if (k == 11) begin
        total++; if (b_wbdata !== 32'h0000_BEEF || b_wbrd !== 5'd4) begin bad++; $display("FAIL b2b_resp2 got=%0h/%0d exp=beef/4", b_wbdata, b_wbrd); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    req_we = 1'b0; req_addr = 32'h14; req_rd = 5'd9; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    total++; if (b_memrd !== 1'b1) begin bad++; $display("FAIL rm_rd got=%0b exp=1", b_memrd); end
    @(posedge clk); #1;
    total++; if (b_memrd !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL rm_wait got=%0b%0b exp=00", b_memrd, b_ready); end
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    total++; if (b_ready !== 1'b1 || b_busy !== 1'b0 || b_memrd !== 1'b0) begin bad++; $display("FAIL rm_idle got=%0b%0b%0b exp=100", b_ready, b_busy, b_memrd); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (b_wbv === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rm_nowb got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
